// File: rtl/mem_wb_stage.sv
// mem_wb_stage: EX/MEM and MEM/WB pipeline registers for the rv32i back end.
// Handles the data-memory handshake (with timeout) and drives the
// register-file write port. stallM freezes E, M and every upstream stage
// while a memory access is outstanding.
module mem_wb_stage #(
  parameter int DPW     = 32,
  parameter int ADW     = 5,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           arst,
  input  logic           regwriteE,
  input  logic           resultsrcE,
  input  logic           memwriteE,
  input  logic [ADW-1:0] RdE,
  input  logic [DPW-1:0] aluresultE,
  input  logic [DPW-1:0] writedataE,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DPW-1:0] dmem_addr,
  output logic [DPW-1:0] dmem_wdata,
  input  logic           dmem_ack,
  input  logic [DPW-1:0] dmem_rdata,
  output logic           stallM,
  output logic           regwriteM,
  output logic [ADW-1:0] RdM,
  output logic [DPW-1:0] aluresultM,
  output logic           we_3,
  output logic [ADW-1:0] addr_3,
  output logic [DPW-1:0] wd_3,
  output logic           bus_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  // M-stage registers
  logic           regwriteM_q, resultsrcM_q, memwriteM_q;
  logic [ADW-1:0] RdM_q;
  logic [DPW-1:0] aluresultM_q, writedataM_q;

  // W-stage registers
  logic           regwriteW_q;
  logic [ADW-1:0] RdW_q;
  logic [DPW-1:0] resultW_q;

  // Handshake FSM
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           bus_err_q;

  logic           memop;
  logic           timeout_hit;
  logic [DPW-1:0] rdata_eff;

  // The M register only advances once its access is done (ack or timeout),
  // so a memory op in M always has a live request; no extra gating needed.
  assign memop      = resultsrcM_q | memwriteM_q;
  assign dmem_req   = memop;
  assign dmem_we    = memwriteM_q;
  assign dmem_addr  = aluresultM_q;
  assign dmem_wdata = writedataM_q;

  // cnt_q counts cycles the request has already been outstanding; the first
  // request cycle (still IDLE) is cycle 0, so the request is held for exactly
  // TIMEOUT cycles before it is abandoned.
  assign timeout_hit = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT - 1));
  assign stallM      = dmem_req & ~dmem_ack & ~timeout_hit;
  assign rdata_eff   = timeout_hit ? '0 : dmem_rdata;

  assign regwriteM  = regwriteM_q;
  assign RdM        = RdM_q;
  assign aluresultM = aluresultM_q;

  assign we_3    = regwriteW_q & (RdW_q != '0);
  assign addr_3  = RdW_q;
  assign wd_3    = resultW_q;
  assign bus_err = bus_err_q;

  // EX/MEM register: capture E whenever the pipe is not frozen
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      regwriteM_q  <= 1'b0;
      resultsrcM_q <= 1'b0;
      memwriteM_q  <= 1'b0;
      RdM_q        <= '0;
      aluresultM_q <= '0;
      writedataM_q <= '0;
    end else if (!stallM) begin
      regwriteM_q  <= regwriteE;
      resultsrcM_q <= resultsrcE;
      memwriteM_q  <= memwriteE;
      RdM_q        <= RdE;
      aluresultM_q <= aluresultE;
      writedataM_q <= writedataE;
    end
  end

  // MEM/WB register: capture result when M completes, else insert a bubble
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      regwriteW_q <= 1'b0;
      RdW_q       <= '0;
      resultW_q   <= '0;
    end else if (!stallM) begin
      regwriteW_q <= regwriteM_q;
      RdW_q       <= RdM_q;
      resultW_q   <= resultsrcM_q ? rdata_eff : aluresultM_q;
    end else begin
      regwriteW_q <= 1'b0;
    end
  end

  // FSM state, wait counter and sticky bus error
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_q | timeout_hit;
    end
  end

  // Next-state logic: enter WAIT on an unacked request, leave on ack/timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (dmem_req && !dmem_ack) begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        if (dmem_ack || timeout_hit) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage: a random instruction stream and a memory
// responder with random latency (including no-ack timeouts), checked every
// cycle against a pipeline-level model of the M and W stages.
module tb_mem_wb_stage;

  localparam int DPW     = 32;
  localparam int ADW     = 5;
  localparam int TIMEOUT = 16;
  localparam int NO_ACK  = 99;

  typedef struct packed {
    logic           rw;
    logic           rs;
    logic           mw;
    logic [ADW-1:0] rd;
    logic [DPW-1:0] alu;
    logic [DPW-1:0] wd;
  } ins_t;

  logic           clk = 1'b0;
  logic           arst;
  logic           regwriteE, resultsrcE, memwriteE;
  logic [ADW-1:0] RdE;
  logic [DPW-1:0] aluresultE, writedataE;
  logic           dmem_req, dmem_we, dmem_ack;
  logic [DPW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic           stallM, regwriteM, we_3, bus_err;
  logic [ADW-1:0] RdM, addr_3;
  logic [DPW-1:0] aluresultM, wd_3;

  mem_wb_stage #(.DPW(DPW), .ADW(ADW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .arst(arst),
    .regwriteE(regwriteE), .resultsrcE(resultsrcE), .memwriteE(memwriteE),
    .RdE(RdE), .aluresultE(aluresultE), .writedataE(writedataE),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stallM(stallM), .regwriteM(regwriteM), .RdM(RdM), .aluresultM(aluresultM),
    .we_3(we_3), .addr_3(addr_3), .wd_3(wd_3), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  ins_t           e_cur, m_ins;
  int             lat_e, lat_m, wcnt;
  logic           w_v, berr_exp;
  logic [ADW-1:0] w_rd;
  logic [DPW-1:0] w_d;
  logic           ovr_v;
  ins_t           ovr_ins;
  int             ovr_lat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ins_t rand_ins();
    ins_t i;
    int   k;
    i     = '0;
    k     = $urandom_range(0, 9);
    i.rd  = ADW'($urandom);
    i.alu = $urandom;
    i.wd  = $urandom;
    case (k)
      0, 1, 2, 3: i.rw = 1'b1;                   // ALU op
      4, 5:       begin i.rw = 1'b1; i.rs = 1'b1; end  // load
      6, 7:       i.mw = 1'b1;                   // store
      8:          ;                              // nop
      default:    begin i.rw = 1'b1; i.rd = '0; end    // write to x0
    endcase
    if (k == 5 && $urandom_range(0, 3) == 0) i.rd = '0;  // load to x0
    return i;
  endfunction

  function automatic int rand_lat();
    int r;
    r = $urandom_range(0, 11);
    if (r < 4) return 0;
    if (r < 9) return r - 3;
    return NO_ACK;
  endfunction

  task automatic drive_e(input ins_t i);
    regwriteE  = i.rw;
    resultsrcE = i.rs;
    memwriteE  = i.mw;
    RdE        = i.rd;
    aluresultE = i.alu;
    writedataE = i.wd;
  endtask

  task automatic model_reset();
    e_cur    = '0;
    m_ins    = '0;
    lat_e    = 0;
    lat_m    = 0;
    wcnt     = 0;
    w_v      = 1'b0;
    w_rd     = '0;
    w_d      = '0;
    berr_exp = 1'b0;
    drive_e(e_cur);
  endtask

  task automatic run_cycles(input int n);
    logic           memop, ack_v, tmo, st;
    logic [DPW-1:0] rd_v;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      memop      = m_ins.rs | m_ins.mw;
      ack_v      = memop && (wcnt == lat_m);
      rd_v       = $urandom;
      dmem_ack   = ack_v;
      dmem_rdata = rd_v;
      #1;
      tmo = memop && !ack_v && (wcnt == TIMEOUT - 1);
      st  = memop && !ack_v && !tmo;
      chk("dmem_req", 64'(dmem_req), 64'(memop));
      if (memop) begin
        chk("dmem_addr",  64'(dmem_addr),  64'(m_ins.alu));
        chk("dmem_we",    64'(dmem_we),    64'(m_ins.mw));
        chk("dmem_wdata", 64'(dmem_wdata), 64'(m_ins.wd));
      end
      chk("stallM",     64'(stallM),     64'(st));
      chk("regwriteM",  64'(regwriteM),  64'(m_ins.rw));
      chk("RdM",        64'(RdM),        64'(m_ins.rd));
      chk("aluresultM", 64'(aluresultM), 64'(m_ins.alu));
      chk("we_3",       64'(we_3),       64'(w_v));
      if (w_v) begin
        chk("addr_3", 64'(addr_3), 64'(w_rd));
        chk("wd_3",   64'(wd_3),   64'(w_d));
      end
      chk("bus_err", 64'(bus_err), 64'(berr_exp));
      // next-cycle model
      berr_exp = berr_exp | tmo;
      if (st) begin
        w_v  = 1'b0;
        wcnt = wcnt + 1;
      end else begin
        w_v   = m_ins.rw && (m_ins.rd != '0);
        w_rd  = m_ins.rd;
        w_d   = m_ins.rs ? (ack_v ? rd_v : '0) : m_ins.alu;
        m_ins = e_cur;
        lat_m = lat_e;
        wcnt  = 0;
      end
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      if (!st) begin
        if (ovr_v) begin
          e_cur = ovr_ins;
          lat_e = ovr_lat;
          ovr_v = 1'b0;
        end else begin
          e_cur = rand_ins();
          lat_e = rand_lat();
        end
        drive_e(e_cur);
      end
    end
  endtask

  initial begin
    ins_t ld;
    ovr_v      = 1'b0;
    arst       = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    model_reset();
    #12;
    chk("rst_dmem_req", 64'(dmem_req), 64'd0);
    chk("rst_stallM",   64'(stallM),   64'd0);
    chk("rst_we_3",     64'(we_3),     64'd0);
    chk("rst_bus_err",  64'(bus_err),  64'd0);
    @(negedge clk);
    arst = 1'b0;

    run_cycles(800);

    // a load that never gets acked: must time out and set bus_err
    ld       = '0;
    ld.rw    = 1'b1;
    ld.rs    = 1'b1;
    ld.rd    = 5'd7;
    ld.alu   = 32'h0000_0100;
    ovr_ins  = ld;
    ovr_lat  = NO_ACK;
    ovr_v    = 1'b1;
    run_cycles(TIMEOUT + 6);
    chk("bus_err_set", 64'(bus_err), 64'd1);

    // another unacked load, then reset while it waits
    ovr_ins = ld;
    ovr_lat = NO_ACK;
    ovr_v   = 1'b1;
    run_cycles(6);
    chk("pre_rst_req", 64'(dmem_req), 64'd1);
    arst = 1'b1;
    #1;
    chk("arst_dmem_req",   64'(dmem_req),   64'd0);
    chk("arst_stallM",     64'(stallM),     64'd0);
    chk("arst_we_3",       64'(we_3),       64'd0);
    chk("arst_wd_3",       64'(wd_3),       64'd0);
    chk("arst_dmem_addr",  64'(dmem_addr),  64'd0);
    chk("arst_regwriteM",  64'(regwriteM),  64'd0);
    chk("arst_bus_err",    64'(bus_err),    64'd0);
    model_reset();
    ovr_v = 1'b0;
    @(negedge clk);
    arst = 1'b0;

    run_cycles(800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
